// File: rtl/ha_rr_scheduler_if.sv
// Handshake bundle between requesters, the round-robin scheduler, the shared
// half adder and the response consumer.
interface ha_rr_scheduler_if #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned IDW  = 2
);
  logic [NREQ-1:0] req_valid;
  logic [NREQ-1:0] req_a;
  logic [NREQ-1:0] req_b;
  logic [NREQ-1:0] req_ready;
  logic            ha_a;
  logic            ha_b;
  logic            ha_sum;
  logic            ha_carry;
  logic            rsp_valid;
  logic            rsp_ready;
  logic [IDW-1:0]  rsp_id;
  logic            rsp_sum;
  logic            rsp_carry;

  modport master (
    output req_valid, req_a, req_b, ha_sum, ha_carry, rsp_ready,
    input  req_ready, ha_a, ha_b, rsp_valid, rsp_id, rsp_sum, rsp_carry
  );

  modport slave (
    input  req_valid, req_a, req_b, ha_sum, ha_carry, rsp_ready,
    output req_ready, ha_a, ha_b, rsp_valid, rsp_id, rsp_sum, rsp_carry
  );
endinterface

// File: rtl/ha_rr_scheduler.sv
// Round-robin scheduler sharing one clocked half adder among NREQ requesters;
// one operation in flight, result returned with the owning requester index.
module ha_rr_scheduler #(
  parameter int unsigned NREQ   = 4,
  parameter int unsigned IDW    = 2,
  parameter int unsigned HA_LAT = 1
) (
  input logic            clk,
  input logic            rstn,
  ha_rr_scheduler_if.slave bus
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t          state, state_nxt;
  logic [IDW-1:0]  rr_ptr;
  logic [IDW-1:0]  id_q;
  logic            a_q, b_q;
  logic [2:0]      lat_cnt;
  logic            rsp_valid_q, rsp_sum_q, rsp_carry_q;
  logic            found;
  logic [IDW-1:0]  win;
  logic [IDW-1:0]  idx;
  logic [NREQ-1:0] grant;

  // First valid requester at or after rr_ptr, wrapping; grant only while out of reset.
  always_comb begin
    found = 1'b0;
    win   = '0;
    idx   = '0;
    grant = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      idx = IDW'((32'(rr_ptr) + k) % NREQ);
      if (!found && bus.req_valid[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
    if (state == IDLE && found && rstn) grant[win] = 1'b1;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (found) state_nxt = ISSUE;
      ISSUE:   state_nxt = WAIT;
      WAIT:    if (lat_cnt == '0) state_nxt = RESP;
      RESP:    if (bus.rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state       <= IDLE;
      rr_ptr      <= '0;
      id_q        <= '0;
      a_q         <= 1'b0;
      b_q         <= 1'b0;
      lat_cnt     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_sum_q   <= 1'b0;
      rsp_carry_q <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: if (found) begin
          a_q  <= bus.req_a[win];
          b_q  <= bus.req_b[win];
          id_q <= win;
        end
        ISSUE: lat_cnt <= 3'(HA_LAT - 1);
        WAIT: begin
          if (lat_cnt == '0) begin
            rsp_sum_q   <= bus.ha_sum;
            rsp_carry_q <= bus.ha_carry;
            rsp_valid_q <= 1'b1;
          end else begin
            lat_cnt <= lat_cnt - 3'd1;
          end
        end
        RESP: if (bus.rsp_ready) begin
          rsp_valid_q <= 1'b0;
          rr_ptr      <= IDW'((32'(id_q) + 32'd1) % NREQ);
        end
        default: ;
      endcase
    end
  end

  assign bus.req_ready = grant;
  assign bus.ha_a      = (state == ISSUE || state == WAIT) && a_q;
  assign bus.ha_b      = (state == ISSUE || state == WAIT) && b_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_id    = id_q;
  assign bus.rsp_sum   = rsp_sum_q;
  assign bus.rsp_carry = rsp_carry_q;

  a_ready_onehot: assert property (@(posedge clk) disable iff (!rstn)
    $onehot0(bus.req_ready));
  a_ready_idle: assert property (@(posedge clk) disable iff (!rstn)
    (bus.req_ready != '0) |-> (state == IDLE));
  a_rsp_hold: assert property (@(posedge clk) disable iff (!rstn)
    (bus.rsp_valid && !bus.rsp_ready) |=>
      (bus.rsp_valid && $stable({bus.rsp_id, bus.rsp_sum, bus.rsp_carry})));
endmodule

// File: tb/tb_ha_rr_scheduler.sv
// Directed bench: two schedulers (HA_LAT=1 and HA_LAT=3), each driving a
// behavioural clocked half adder, checked against hand-computed results.
module tb_ha_rr_scheduler;
  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  ha_rr_scheduler_if #(.NREQ(4), .IDW(2)) i1 ();
  ha_rr_scheduler_if #(.NREQ(4), .IDW(2)) i3 ();

  ha_rr_scheduler #(.NREQ(4), .IDW(2), .HA_LAT(1)) u1 (.clk(clk), .rstn(rstn), .bus(i1.slave));
  ha_rr_scheduler #(.NREQ(4), .IDW(2), .HA_LAT(3)) u3 (.clk(clk), .rstn(rstn), .bus(i3.slave));

  logic [3:0] rv [2];
  logic [3:0] ra [2];
  logic [3:0] rb [2];
  logic       rr [2];

  assign i1.req_valid = rv[0];
  assign i1.req_a     = ra[0];
  assign i1.req_b     = rb[0];
  assign i1.rsp_ready = rr[0];
  assign i3.req_valid = rv[1];
  assign i3.req_a     = ra[1];
  assign i3.req_b     = rb[1];
  assign i3.rsp_ready = rr[1];

  // Behavioural half adders: 1-stage and 3-stage registered pipelines.
  logic       s1, c1;
  logic [2:0] s3, c3;
  always @(posedge clk) begin
    s1 <= i1.ha_a ^ i1.ha_b;
    c1 <= i1.ha_a & i1.ha_b;
    s3 <= {s3[1:0], i3.ha_a ^ i3.ha_b};
    c3 <= {c3[1:0], i3.ha_a & i3.ha_b};
  end
  assign i1.ha_sum   = s1;
  assign i1.ha_carry = c1;
  assign i3.ha_sum   = s3[2];
  assign i3.ha_carry = c3[2];

  logic [3:0] rdy [2];
  logic [1:0] oid [2];
  logic       ov [2], os [2], oc [2], oha [2], ohb [2];
  assign rdy[0] = i1.req_ready;  assign rdy[1] = i3.req_ready;
  assign oid[0] = i1.rsp_id;     assign oid[1] = i3.rsp_id;
  assign ov[0]  = i1.rsp_valid;  assign ov[1]  = i3.rsp_valid;
  assign os[0]  = i1.rsp_sum;    assign os[1]  = i3.rsp_sum;
  assign oc[0]  = i1.rsp_carry;  assign oc[1]  = i3.rsp_carry;
  assign oha[0] = i1.ha_a;       assign oha[1] = i3.ha_a;
  assign ohb[0] = i1.ha_b;       assign ohb[1] = i3.ha_b;

  int unsigned n_chk  = 0;
  int unsigned n_fail = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic wait_grant(input int w);
    bit ok;
    ok = 1'b0;
    #1;
    for (int i = 0; i < 32 && !ok; i++) begin
      if (rdy[w] != 4'b0) ok = 1'b1;
      else @(negedge clk);
    end
    check("grant_timeout", 32'(ok), 32'd1);
  endtask

  task automatic wait_valid(input int w);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 32 && !ok; i++) begin
      @(negedge clk);
      if (ov[w]) ok = 1'b1;
    end
    check("rsp_timeout", 32'(ok), 32'd1);
  endtask

  // One full transaction for requester id, optionally with other requesters also valid.
  task automatic do_op(input int w, input int id, input logic a, input logic b,
                       input logic [3:0] extra);
    int unsigned lat;
    logic [3:0]  one;
    lat = (w == 0) ? 1 : 3;
    one = 4'b0001 << id;
    rr[w] = 1'b1;
    ra[w] = {4{~a}};
    rb[w] = {4{~b}};
    ra[w][id] = a;
    rb[w][id] = b;
    rv[w] = one | extra;
    #1 check("grant", 32'(rdy[w]), 32'(one));
    @(negedge clk);
    rv[w] = 4'b0;
    check("issue_ha", 32'({oha[w], ohb[w]}), 32'({a, b}));
    repeat (lat) @(negedge clk);
    check("early_rsp", 32'(ov[w]), 32'd0);
    @(negedge clk);
    check("rsp_valid", 32'(ov[w]), 32'd1);
    check("rsp_id", 32'(oid[w]), 32'(id));
    check("rsp_sum", 32'(os[w]), 32'(a ^ b));
    check("rsp_carry", 32'(oc[w]), 32'(a & b));
    @(negedge clk);
    check("rsp_done", 32'(ov[w]), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] ta, tb;
    int unsigned e;
    bit seen;

    rstn = 1'b0;
    for (int w = 0; w < 2; w++) begin
      rv[w] = 4'b1111; ra[w] = 4'b0; rb[w] = 4'b0; rr[w] = 1'b0;
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_ready", 32'(rdy[0]), 32'd0);
    check("rst_valid", 32'(ov[0]), 32'd0);
    check("rst_ha", 32'({oha[0], ohb[0]}), 32'd0);
    check("rst_ptr", 32'(u1.rr_ptr), 32'd0);
    rv[0] = 4'b0; rv[1] = 4'b0; rstn = 1'b1;
    @(negedge clk);

    do_op(0, 2, 1'b1, 1'b1, 4'b0000);

    // Round robin from a fresh reset: all requesters held valid.
    rstn = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    ta = 4'b0110; tb = 4'b1100;
    ra[0] = ta; rb[0] = tb; rr[0] = 1'b1; rv[0] = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      e = k % 4;
      wait_grant(0);
      check("rr_grant", 32'(rdy[0]), 32'(4'b0001 << e));
      wait_valid(0);
      check("rr_id", 32'(oid[0]), e);
      check("rr_sum", 32'(os[0]), 32'(ta[e] ^ tb[e]));
      check("rr_carry", 32'(oc[0]), 32'(ta[e] & tb[e]));
      @(negedge clk);
    end
    rv[0] = 4'b0;

    // Backpressure: pointer is 1, grant goes to 1, then hold RESP for 5 cycles.
    rr[0] = 1'b0; ra[0] = 4'b0010; rb[0] = 4'b0000; rv[0] = 4'b1111;
    wait_grant(0);
    check("bp_grant", 32'(rdy[0]), 32'b0010);
    wait_valid(0);
    for (int k = 0; k < 5; k++) begin
      check("bp_hold", 32'({ov[0], oid[0], os[0], oc[0], rdy[0]}), 32'({1'b1, 2'd1, 1'b1, 1'b0, 4'b0}));
      @(negedge clk);
    end
    rr[0] = 1'b1;
    @(negedge clk);
    check("bp_release_valid", 32'(ov[0]), 32'd0);
    check("bp_release_grant", 32'(rdy[0]), 32'b0100);
    rv[0] = 4'b0;
    #1;

    // Wrap and skip.
    do_op(0, 2, 1'b0, 1'b1, 4'b0000);
    check("ptr_after_2", 32'(u1.rr_ptr), 32'd3);
    do_op(0, 1, 1'b1, 1'b0, 4'b0000);
    check("ptr_after_wrap", 32'(u1.rr_ptr), 32'd2);

    // Reset during WAIT drops the operation.
    ra[0] = 4'b1000; rb[0] = 4'b1000; rr[0] = 1'b1; rv[0] = 4'b1000;
    #1 check("mid_grant", 32'(rdy[0]), 32'b1000);
    @(negedge clk);
    rv[0] = 4'b0;
    @(negedge clk);
    rstn = 1'b0;
    @(negedge clk);
    check("mid_rst_valid", 32'(ov[0]), 32'd0);
    check("mid_rst_ptr", 32'(u1.rr_ptr), 32'd0);
    rstn = 1'b1;
    seen = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (ov[0]) seen = 1'b1;
    end
    check("mid_no_rsp", 32'(seen), 32'd0);
    do_op(0, 1, 1'b0, 1'b0, 4'b1000);

    // Every (a,b) from every requester on both latencies.
    for (int w = 0; w < 2; w++)
      for (int id = 0; id < 4; id++)
        for (int ab = 0; ab < 4; ab++)
          do_op(w, id, ab[1], ab[0], 4'b0000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
